// File: rtl/lwr_prf_core.sv
`default_nettype none
// ============================================================================
// Module   : lwr_prf_core
// Brief    : LWR-style PRF. An LFSR seeded from the request index expands into
//            N coefficients, which are dotted with a stored key mod Q. The sum
//            is then rounded down to mod P.
// Revision : 1.0  initial release
// ============================================================================
module lwr_prf_core #(
  parameter int          N    = 8,
  parameter int          Q    = 1024,
  parameter int          P    = 32,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int LQ = $clog2(Q),
  localparam int LP = $clog2(P),
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_wr_en,
  input  logic [AW-1:0] key_wr_addr,
  input  logic [LQ-1:0] key_wr_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [15:0]   req_index,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LP-1:0] prf_out,
  output logic          busy
);

  localparam logic [15:0]   c_lfsr_tap = 16'hB400;
  localparam logic [AW-1:0] c_last_cnt = AW'(N - 1);
  localparam logic [LQ-1:0] c_half     = LQ'(Q / (2 * P));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LQ-1:0]   r_key [N];
  logic [15:0]     r_lfsr;
  logic [LQ-1:0]   r_acc;
  logic [AW-1:0]   r_cnt;
  logic [LP-1:0]   r_prf;

  logic [15:0]     w_seed_mix;
  logic [15:0]     w_lfsr_load;
  logic [15:0]     w_lfsr_nxt;
  logic [LQ-1:0]   w_a;
  logic [2*LQ-1:0] w_prod;
  logic [LQ-1:0]   w_acc_nxt;
  logic [LQ-1:0]   w_round;
  logic [LP-1:0]   w_prf;
  logic            w_unused_bits;

  // An all-zero LFSR state would lock up, so that seed is replaced by 1.
  assign w_seed_mix  = req_index ^ SEED;
  assign w_lfsr_load = (w_seed_mix == 16'h0000) ? 16'h0001 : w_seed_mix;
  assign w_lfsr_nxt  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_tap : 16'h0000);
  assign w_a         = w_lfsr_nxt[LQ-1:0];

  // Full-width product; only the low LQ bits survive the mod-Q reduction.
  assign w_prod      = {{LQ{1'b0}}, w_a} * {{LQ{1'b0}}, r_key[r_cnt]};
  assign w_acc_nxt   = r_acc + w_prod[LQ-1:0];

  // Adding half a step before taking the top LP bits rounds to nearest.
  // Carry-out past bit LQ-1 is dropped, so the top value wraps to zero.
  assign w_round     = w_acc_nxt + c_half;
  assign w_prf       = w_round[LQ-1 -: LP];

  assign w_unused_bits = ^{w_prod[2*LQ-1:LQ], w_round[LQ-LP-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = RUN;
      RUN:     if (r_cnt == c_last_cnt) w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_prf  <= '0;
      for (int i = 0; i < N; i++) begin
        r_key[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (key_wr_en) begin
            r_key[key_wr_addr] <= key_wr_data;
          end
          if (req_valid) begin
            r_lfsr <= w_lfsr_load;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_lfsr <= w_lfsr_nxt;
          r_acc  <= w_acc_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == c_last_cnt) begin
            r_prf <= w_prf;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == OUT);
  assign prf_out   = r_prf;

endmodule
`default_nettype wire

// File: tb/tb_lwr_prf_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_lwr_prf_core
// Brief    : Directed and randomized checks of lwr_prf_core against an
//            arithmetic PRF model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lwr_prf_core;

  localparam int          N    = 8;
  localparam int          Q    = 1024;
  localparam int          P    = 32;
  localparam int          LQ   = 10;
  localparam int          LP   = 5;
  localparam int          AW   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_wr_en;
  logic [AW-1:0] key_wr_addr;
  logic [LQ-1:0] key_wr_data;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   req_index;
  logic          out_valid;
  logic          out_ready;
  logic [LP-1:0] prf_out;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned model_key [N];

  lwr_prf_core #(.N(N), .Q(Q), .P(P), .SEED(SEED)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_wr_en   (key_wr_en),
    .key_wr_addr (key_wr_addr),
    .key_wr_data (key_wr_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .prf_out     (prf_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: x-seeded LFSR coefficients dotted with the key mod Q,
  // then rounded to the nearest multiple of Q/P and reduced mod P.
  function automatic int unsigned model_prf(input logic [15:0] idx);
    int unsigned lfsr;
    int unsigned acc;
    lfsr = 32'(idx ^ SEED);
    if (lfsr == 0) lfsr = 1;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      lfsr = (lfsr >> 1) ^ (((lfsr & 1) != 0) ? 32'hB400 : 32'h0);
      acc  = (acc + (lfsr % Q) * model_key[i]) % Q;
    end
    return ((acc + Q / (2 * P)) / (Q / P)) % P;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input int addr, input int unsigned data);
    key_wr_en   = 1'b1;
    key_wr_addr = AW'(addr);
    key_wr_data = LQ'(data);
    tick();
    key_wr_en   = 1'b0;
  endtask

  task automatic load_key(input int unsigned data, input bit randomize);
    for (int i = 0; i < N; i++) begin
      model_key[i] = randomize ? $urandom_range(0, Q - 1) : data;
      write_key(i, model_key[i]);
    end
  endtask

  task automatic accept(input string tag, input logic [15:0] idx);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_index = idx;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // elapsed: cycles already spent since the acceptance edge
  task automatic wait_out(input string tag, input int elapsed, input int unsigned exp, input int hold);
    int cyc;
    cyc = elapsed;
    while (!out_valid && cyc < 4 * N) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(N));
    check({tag, "_prf"}, 32'(prf_out), exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold"}, {26'd0, out_valid, req_ready, busy, prf_out},
            {26'd0, 1'b1, 1'b0, 1'b1, LP'(exp)});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {29'd0, out_valid, req_ready, busy}, 32'b010);
  endtask

  task automatic run_req(input string tag, input logic [15:0] idx, input int unsigned exp, input int hold);
    accept(tag, idx);
    wait_out(tag, 0, exp, hold);
  endtask

  initial begin
    bit seen_valid;
    logic [15:0] idx;

    rst = 1'b1; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
    req_valid = 1'b0; req_index = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) model_key[i] = 0;

    #3;
    check("in_reset", {24'd0, req_ready, busy, out_valid, prf_out}, {24'd0, 3'b100, 5'd0});
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_prf_out",   32'(prf_out),   32'd0);

    run_req("zero_key", 16'h0000, 0, 0);

    write_key(0, 1);
    model_key[0] = 1;
    run_req("key0_one", 16'h0000, 20, 0);

    run_req("backpressure", 16'h0000, 20, 5);

    // Index equal to the seed mask forces the substitute LFSR seed.
    run_req("seed_zero", SEED, model_prf(SEED), 1);

    load_key(Q - 1, 1'b0);
    run_req("key_max", 16'hFFFF, model_prf(16'hFFFF), 0);

    for (int it = 0; it < 8; it++) begin
      load_key(0, 1'b1);
      idx = 16'($urandom);
      run_req("random", idx, model_prf(idx), $urandom_range(0, 3));
    end

    // A key write while RUN is active must be dropped.
    load_key(0, 1'b0);
    accept("wr_in_run", 16'h0000);
    tick();
    write_key(0, 1);
    wait_out("wr_in_run", 2, 0, 0);
    run_req("wr_in_run_follow", 16'h0000, 0, 0);

    // Reset mid-computation aborts the request and wipes the key.
    write_key(0, 1);
    model_key[0] = 1;
    accept("mid_rst", 16'h0000);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_async", {29'd0, out_valid, req_ready, busy}, 32'b010);
    #2;
    rst = 1'b0;
    for (int i = 0; i < N; i++) model_key[i] = 0;
    seen_valid = 1'b0;
    for (int c = 0; c < N + 3; c++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("mid_rst_no_valid", 32'(seen_valid), 32'd0);
    check("mid_rst_idle", {29'd0, out_valid, req_ready, busy}, 32'b010);
    run_req("mid_rst_follow", 16'h0000, model_prf(16'h0000), 0);
    check("mid_rst_key_clr", 32'(prf_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lwr_prf_core.md
LWR_PRF_CORE -- requirements
Module: lwr_prf_core

Interface
REQ-001 The block SHALL have the parameter N, default 8, meaning the LWR dimension (key length and number of MAC terms).
REQ-002 The block SHALL have the parameter Q, default 1024, meaning the inner modulus; it is a power of 2 with LQ = log2(Q) <= 16.
REQ-003 The block SHALL have the parameter P, default 32, meaning the output modulus; it is a power of 2, P < Q, LP = log2(P).
REQ-004 The block SHALL have the parameter SEED, default 16'hACE1, meaning the LFSR seed mask.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the ports key_wr_en (input, 1), key_wr_addr (input, clog2(N)) and key_wr_data (input, LQ), forming the key-word write port.
REQ-008 The block SHALL have the ports req_valid (input, 1), req_ready (output, 1) and req_index (input, 16), forming the PRF request handshake and input x.
REQ-009 The block SHALL have the ports out_valid (output, 1), out_ready (input, 1) and prf_out (output, LP), forming the result handshake; prf_out feeds the encrypt/decrypt prf_out input.
REQ-010 The block SHALL have the port busy, output, 1 bit, which is high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, RUN and OUT; req_ready SHALL equal (state == IDLE).
REQ-012 A key write in IDLE with key_wr_en=1 SHALL set key[key_wr_addr] <= key_wr_data at the clock edge; key writes in RUN or OUT SHALL be ignored.
REQ-013 Acceptance (IDLE, req_valid=1) SHALL load lfsr <= req_index ^ SEED (16'h0001 if that is zero), acc <= 0 and cnt <= 0, and SHALL move the FSM to RUN.
REQ-014 LFSR step: a 16-bit Galois right-shift; nxt = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
REQ-015 Each RUN cycle SHALL perform lfsr <= nxt; a = nxt[LQ-1:0]; acc <= (acc + a*key[cnt]) mod Q (LQ-bit truncation); cnt <= cnt+1.
REQ-016 RUN SHALL last exactly N cycles; on the Nth RUN edge the FSM SHALL enter OUT and prf_out SHALL be registered as ((acc_final + Q/(2P)) >> (LQ-LP)) mod P (round-to-nearest, wrapping to 0 at the top).
REQ-017 Latency: out_valid SHALL first be high N cycles after the acceptance edge.
REQ-018 In OUT, out_valid=1; prf_out and out_valid SHALL hold stable while out_ready=0.
REQ-019 On out_valid and out_ready both high, the FSM SHALL return to IDLE at that edge; req_ready rises only in the following cycle (no same-cycle re-accept).
REQ-020 prf_out SHALL retain its last value after leaving OUT until the next OUT entry.
REQ-021 Intermediate products SHALL be at least 2*LQ bits wide before the mod-Q truncation; there is no overflow outside mod Q.

Reset
REQ-022 While rst=1 (asynchronously), the state SHALL be IDLE, out_valid=0, prf_out=0, busy=0, req_ready=1, acc=0, cnt=0, lfsr=0, and all key words=0.
REQ-023 Reset asserted during RUN or OUT SHALL abort the computation with no out_valid pulse and SHALL clear the key.

Verification
REQ-024 Reset then idle: the bench SHALL check req_ready=1, busy=0, out_valid=0, prf_out=0.
REQ-025 Zero key, index 0 accepted: the bench SHALL check out_valid high exactly 8 cycles later with prf_out=0.
REQ-026 key[0]=1, others 0, index 0: seed 0xACE1 -> nxt 0xE270, a0=624; the bench SHALL check prf_out=(624+16)>>5=20.
REQ-027 Backpressure: with out_ready held 0 for 5 cycles in OUT, the bench SHALL check that prf_out and out_valid are stable, req_ready=0 and busy=1; after out_ready=1 for 1 cycle, IDLE is reached the next cycle.
REQ-028 Writing key[0]=1 during RUN of a zero-key request: the bench SHALL check that the result is 0 and that a follow-up index-0 request also returns 0 (write ignored).
REQ-029 rst pulsed mid-RUN after key[0]=1 was loaded: the bench SHALL check that there is no out_valid pulse, that the block is in IDLE, and that a new index-0 request returns 0 (key cleared).
